// File: rtl/approx_mult_seq.sv
// Nibble-serial approximate unsigned multiplier: one 4x4 partial product per clock,
// each block exact or LSB-truncated depending on the mode latched at accept.
module approx_mult_seq #(
  parameter int W     = 8,
  parameter int TRUNC = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [1:0]     MODE,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] R,
  output logic           busy
);

  localparam int NB = W / 4;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int SW = IW + 1;
  localparam logic [7:0] TRUNC_MASK = 8'hFF << TRUNC;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg, state_next;
  logic [W-1:0]     a_reg, b_reg;
  logic [1:0]       mode_reg;
  logic [2*W-1:0]   acc_reg;
  logic [IW-1:0]    i_reg, j_reg;

  logic [3:0]       a_nib [NB];
  logic [3:0]       b_nib [NB];
  logic [3:0]       a_sel, b_sel;
  logic [7:0]       prod, blk;
  logic [SW-1:0]    diag;
  logic             approx;
  logic             last;
  logic [2*W-1:0]   weighted;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[4*gi +: 4];
      assign b_nib[gi] = b_reg[4*gi +: 4];
    end
  endgenerate

  assign a_sel = a_nib[i_reg];
  assign b_sel = b_nib[j_reg];
  assign prod  = {4'b0000, a_sel} * {4'b0000, b_sel};
  assign diag  = {1'b0, i_reg} + {1'b0, j_reg};
  assign last  = (i_reg == IW'(NB - 1)) && (j_reg == IW'(NB - 1));

  // Mode 1 approximates only the low-significance diagonals (i+j < NB-1).
  always_comb begin
    approx = 1'b1;
    case (mode_reg)
      2'd0:    approx = 1'b0;
      2'd1:    approx = (diag < SW'(NB - 1));
      default: approx = 1'b1;
    endcase
  end

  assign blk      = approx ? (prod & TRUNC_MASK) : prod;
  assign weighted = (2*W)'(blk) << {diag, 2'b00};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = CALC;
      CALC:    if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      mode_reg  <= '0;
      acc_reg   <= '0;
      i_reg     <= '0;
      j_reg     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= A;
            b_reg    <= B;
            mode_reg <= MODE;
            acc_reg  <= '0;
            i_reg    <= '0;
            j_reg    <= '0;
          end
        end
        CALC: begin
          acc_reg <= acc_reg + weighted;
          // i walks the multiplicand nibbles fastest, so step k = j*NB + i
          if (i_reg == IW'(NB - 1)) begin
            i_reg <= '0;
            j_reg <= j_reg + IW'(1);
          end else begin
            i_reg <= i_reg + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign R         = acc_reg;

endmodule

// File: tb/tb_approx_mult_seq.sv
// Directed bench for approx_mult_seq: W=8 and W=16 instances, hand-computed products.
module tb_approx_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        v8, rdy8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [1:0]  m8;
  logic [15:0] r8;

  logic        v16, rdy16, ov16, or16, busy16;
  logic [15:0] a16, b16;
  logic [1:0]  m16;
  logic [31:0] r16;

  int checks   = 0;
  int failures = 0;

  approx_mult_seq #(.W(8), .TRUNC(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .A(a8), .B(b8), .MODE(m8),
    .out_valid(ov8), .out_ready(or8), .R(r8), .busy(busy8)
  );

  approx_mult_seq #(.W(16), .TRUNC(2)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .A(a16), .B(b16), .MODE(m16),
    .out_valid(ov16), .out_ready(or16), .R(r16), .busy(busy16)
  );

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                      input logic [15:0] exp, input string name);
    int lat;
    @(negedge clk);
    checks++;
    if (rdy8 !== 1'b1) begin
      failures++;
      $display("FAIL %s in_ready_before_accept got=%b want=1", name, rdy8);
    end
    a8 = a; b8 = b; m8 = m; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0; a8 = ~a; b8 = 8'h5A; m8 = ~m;
    lat = 0;
    while (ov8 !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL %s latency got=%0d want=4", name, lat);
    end
    checks++;
    if (r8 !== exp) begin
      failures++;
      $display("FAIL %s R got=%h want=%h", name, r8, exp);
    end
    $display("txn %s W=8 A=%h B=%h MODE=%0d R=%h expect=%h lat=%0d", name, a, b, m, r8, exp, lat);
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    checks++;
    if (rdy8 !== 1'b1 || ov8 !== 1'b0) begin
      failures++;
      $display("FAIL %s handshake in_ready=%b out_valid=%b want 1/0", name, rdy8, ov8);
    end
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                       input logic [31:0] exp, input string name);
    int lat;
    @(negedge clk);
    a16 = a; b16 = b; m16 = m; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0; a16 = 16'h1234; b16 = 16'hBEEF; m16 = 2'd2;
    lat = 0;
    while (ov16 !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL %s latency got=%0d want=16", name, lat);
    end
    checks++;
    if (r16 !== exp) begin
      failures++;
      $display("FAIL %s R got=%h want=%h", name, r16, exp);
    end
    $display("txn %s W=16 A=%h B=%h MODE=%0d R=%h expect=%h lat=%0d", name, a, b, m, r16, exp, lat);
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    checks++;
    if (rdy16 !== 1'b1 || ov16 !== 1'b0) begin
      failures++;
      $display("FAIL %s handshake in_ready=%b out_valid=%b want 1/0", name, rdy16, ov16);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    v8 = 0; or8 = 0; a8 = 0; b8 = 0; m8 = 0;
    v16 = 0; or16 = 0; a16 = 0; b16 = 0; m16 = 0;
    #12;
    checks++;
    if (rdy8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0 || r8 !== 16'h0) begin
      failures++;
      $display("FAIL reset8 rdy=%b ov=%b busy=%b R=%h want 1/0/0/0000", rdy8, ov8, busy8, r8);
    end
    checks++;
    if (rdy16 !== 1'b1 || ov16 !== 1'b0 || busy16 !== 1'b0 || r16 !== 32'h0) begin
      failures++;
      $display("FAIL reset16 rdy=%b ov=%b busy=%b R=%h want 1/0/0/0", rdy16, ov16, busy16, r16);
    end
    $display("txn reset rdy8=%b ov8=%b R8=%h rdy16=%b ov16=%b R16=%h", rdy8, ov8, r8, rdy16, ov16, r16);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_modes;
    run8(8'hFF, 8'hFF, 2'd0, 16'hFE01, "ff_mode0");
    run8(8'hFF, 8'hFF, 2'd1, 16'hFE00, "ff_mode1");
    run8(8'hFF, 8'hFF, 2'd2, 16'hFCE0, "ff_mode2");
    run8(8'hFF, 8'hFF, 2'd3, 16'hFCE0, "ff_mode3");
    run8(8'h0D, 8'h0B, 2'd0, 16'h008F, "db_mode0");
    run8(8'h0D, 8'h0B, 2'd2, 16'h008C, "db_mode2");
  endtask

  task automatic test_backpressure;
    logic bad_r, bad_rdy, bad_ov;
    @(negedge clk);
    a8 = 8'h0D; b8 = 8'h0B; m8 = 2'd0; v8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'hFF; b8 = 8'hFF; m8 = 2'd2;
    for (int n = 0; n < 50 && ov8 !== 1'b1; n++) begin
      @(posedge clk); #1;
    end
    bad_r = 0; bad_rdy = 0; bad_ov = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (r8 !== 16'h008F) bad_r = 1;
      if (rdy8 !== 1'b0) bad_rdy = 1;
      if (ov8 !== 1'b1) bad_ov = 1;
    end
    checks++;
    if (bad_r) begin
      failures++;
      $display("FAIL bp_r_stable got=%h want=008f", r8);
    end
    checks++;
    if (bad_rdy) begin
      failures++;
      $display("FAIL bp_in_ready got=%b want=0 throughout", rdy8);
    end
    checks++;
    if (bad_ov) begin
      failures++;
      $display("FAIL bp_out_valid got=%b want=1 throughout", ov8);
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    v8 = 1'b0;
    checks++;
    if (rdy8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL bp_release rdy=%b ov=%b busy=%b want 1/0/0", rdy8, ov8, busy8);
    end
    $display("txn backpressure R=%h held 10 cycles, release rdy=%b", r8, rdy8);
  endtask

  task automatic test_reset_mid;
    logic saw_valid;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; m8 = 2'd0; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ov8 !== 1'b0 || busy8 !== 1'b0 || r8 !== 16'h0 || rdy8 !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid ov=%b busy=%b R=%h rdy=%b want 0/0/0000/1", ov8, busy8, r8, rdy8);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (ov8 !== 1'b0) saw_valid = 1;
    end
    checks++;
    if (saw_valid) begin
      failures++;
      $display("FAIL reset_mid_no_result got out_valid=1 want 0");
    end
    $display("txn reset_mid aborted, ov8=%b R8=%h", ov8, r8);
    run8(8'h12, 8'h34, 2'd0, 16'h03A8, "after_reset");
  endtask

  task automatic test_w16;
    logic [15:0] a, b;
    run16(16'hFFFF, 16'hFFFF, 2'd0, 32'hFFFE0001, "w16_ffff");
    for (int n = 0; n < 4; n++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      run16(a, b, 2'd0, 32'(a) * 32'(b), "w16_rand");
    end
  endtask

  initial begin
    test_reset;
    test_modes;
    test_backpressure;
    test_reset_mid;
    test_w16;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
